decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode (ID) stage of the MIPS pipeline. Sits between fetch and execute.
- Holds the IF/ID pipeline register and decodes the instruction.
- Drives the register file read addresses and produces the ID/EX control/immediate register, cycle-aligned with the register file's registered s1val/s2val.
- Detects load-use hazards (stall plus bubble) and honours branch flushes from EX.

Parameters:
- PC_W, 32, width of program-counter fields.
- LOAD_USE_STALL, 1, 1 = load-use hazard detection enabled; 0 = stall_out tied 0.

Ports:
- clk  in  1  pipeline clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_insn  in  32  fetched instruction word.
- if_pc  in  PC_W  PC of if_insn.
- flush  in  1  branch/jump taken in EX; kill younger instructions.
- stall_out  out  1  hold fetch PC/instruction (combinational).
- rf_source1  out  5  register file read address A (= IF/ID rs).
- rf_source2  out  5  register file read address B (= IF/ID rt).
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_pc  out  PC_W  PC of the ID/EX instruction.
- ex_opcode  out  6  insn[31:26].
- ex_funct  out  6  insn[5:0].
- ex_shamt  out  5  insn[10:6].
- ex_rs, ex_rt  out  5 each  source register numbers (used by the forwarding unit).
- ex_dest  out  5  destination register number.
- ex_imm  out  32  extended immediate.
- ex_alu_src_imm  out  1  ALU operand B comes from ex_imm.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_reg_write  out  1  writes ex_dest.
- ex_illegal  out  1  undecoded opcode/funct.

Behaviour:
- Reset (async, rst_n=0): IF/ID valid=0, IF/ID insn=0, IF/ID pc=0; every ex_* output = 0. stall_out = 0 while reset is asserted. Release is synchronous to the next posedge.
- IF/ID register, on each posedge:
  - flush=1: valid←0 (flush has priority over stall).
  - else stall_out=1: hold contents.
  - else: valid←if_valid, insn←if_insn, pc←if_pc.
- rf_source1/rf_source2 are combinational from the IF/ID insn (rs=[25:21], rt=[20:16]). The register file samples them at the same posedge that loads ID/EX, so s1val/s2val and the ex_* outputs are valid in the same cycle. Latency from if_insn accepted to ex_* valid = 2 posedges.
- Decode (combinational from IF/ID):
  - R-type (op 0x00): dest=rd; reg_write=1; uses rs,rt. funct 0x08 (jr): reg_write=0, uses rs only. funct 0x00/0x02/0x03 (sll/srl/sra): uses rt only. Legal funct: 00,02,03,08,20–27,2A,2B; all others are illegal.
  - I-ALU (op 08,09,0A,0B,0C,0D,0E,0F): dest=rt; alu_src_imm=1; reg_write=1; uses rs, except lui (0F), which uses none.
  - Immediate extension: andi/ori/xori zero-extend imm; all other opcodes sign-extend imm.
  - lw (0x23): mem_read=1, reg_write=1, dest=rt, alu_src_imm=1, uses rs.
  - sw (0x2B): mem_write=1, alu_src_imm=1, uses rs,rt.
  - beq/bne (04/05): uses rs,rt; no write.
  - j (02): no regs.
  - jal (03): dest=31, reg_write=1.
  - Any other opcode: illegal=1; all write/mem controls 0.
  - dest==0 forces reg_write=0.
- Load-use hazard (LOAD_USE_STALL=1): stall_out = IF/ID valid & ex_valid & ex_mem_read & ex_dest≠0 & ((uses_rs & ex_dest==rs) | (uses_rt & ex_dest==rt)) & !flush.
- ID/EX register, on each posedge:
  - flush=1 or stall_out=1: ex_valid←0 (bubble); all control bits (mem_read, mem_write, reg_write) ←0; other fields don't-care but held at 0.
  - else: load decoded fields; ex_valid←IF/ID valid. If IF/ID is invalid, all control bits ←0.
- A stall lasts exactly 1 cycle: after the bubble, ex_mem_read=0, so the hazard clears.
- Back-to-back loads to the same register each stall independently.
- Reset mid-stall: all state is cleared immediately; no stall or bubble survives.

Test Plan:
- Reset then `addi $5,$0,7` (0x20050007) with if_valid=1 → 2 posedges later: ex_valid=1, ex_dest=5, ex_imm=0x00000007, ex_alu_src_imm=1, ex_reg_write=1. rf_source1=0 one cycle earlier.
- `ori $3,$3,0x8000` (0x34638000) → ex_imm=0x00008000 (zero-extended). `addi $3,$3,-1` (0x2063FFFF) → ex_imm=0xFFFFFFFF.
- `lw $8,0($9)` followed by `add $10,$8,$2` → stall_out=1 for exactly 1 cycle; the add is held in IF/ID; ex_valid=0 (bubble) for one cycle; then the add enters with ex_rs=8. `lw $0,...` followed by `add` using $0 → no stall.
- flush=1 in the same cycle as a load-use stall → stall_out=0; IF/ID valid=0 and ex_valid=0 after the edge; the next fetched instruction proceeds normally.
- Opcode 0x3F and R-type funct 0x01 → ex_illegal=1, ex_reg_write=0, ex_mem_write=0. `sll $0,$1,2` → ex_reg_write=0.
- Assert rst_n=0 asynchronously mid-stall (between edges) → all ex_* outputs and stall_out go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, field decode, load-use hazard detection
// and the ID/EX register that lines up with the register file's registered read data.
module decode_stage #(
  parameter int PC_W           = 32,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_insn,
  input  logic [PC_W-1:0] if_pc,
  input  logic            flush,
  output logic            stall_out,
  output logic [4:0]      rf_source1,
  output logic [4:0]      rf_source2,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_shamt,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_dest,
  output logic [31:0]     ex_imm,
  output logic            ex_alu_src_imm,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  logic            r_ifid_valid;
  logic [31:0]     r_ifid_insn;
  logic [PC_W-1:0] r_ifid_pc;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;
  logic [4:0]  w_dest;
  logic [31:0] w_imm;
  logic        w_zext;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_alu_src_imm;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_illegal;
  logic        w_hazard;
  logic        w_bubble;

  assign w_op    = r_ifid_insn[31:26];
  assign w_rs    = r_ifid_insn[25:21];
  assign w_rt    = r_ifid_insn[20:16];
  assign w_rd    = r_ifid_insn[15:11];
  assign w_funct = r_ifid_insn[5:0];
  assign w_imm16 = r_ifid_insn[15:0];

  assign rf_source1 = w_rs;
  assign rf_source2 = w_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_insn  <= '0;
      r_ifid_pc    <= '0;
    end else if (flush) begin
      r_ifid_valid <= 1'b0;
    end else if (!stall_out) begin
      r_ifid_valid <= if_valid;
      r_ifid_insn  <= if_insn;
      r_ifid_pc    <= if_pc;
    end
  end

  always_comb begin
    w_dest        = 5'd0;
    w_zext        = 1'b0;
    w_use_rs      = 1'b0;
    w_use_rt      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_illegal     = 1'b0;
    case (w_op)
      6'h00: begin
        w_dest = w_rd;
        case (w_funct)
          6'h00, 6'h02, 6'h03: begin
            w_reg_write = 1'b1;
            w_use_rt    = 1'b1;
          end
          6'h08: w_use_rs = 1'b1;
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            w_reg_write = 1'b1;
            w_use_rs    = 1'b1;
            w_use_rt    = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_dest        = w_rt;
        w_alu_src_imm = 1'b1;
        w_reg_write   = 1'b1;
        w_use_rs      = (w_op != 6'h0F);
        w_zext        = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
      end
      6'h23: begin
        w_dest        = w_rt;
        w_alu_src_imm = 1'b1;
        w_mem_read    = 1'b1;
        w_reg_write   = 1'b1;
        w_use_rs      = 1'b1;
      end
      6'h2B: begin
        w_alu_src_imm = 1'b1;
        w_mem_write   = 1'b1;
        w_use_rs      = 1'b1;
        w_use_rt      = 1'b1;
      end
      6'h04, 6'h05: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'h02: ;
      6'h03: begin
        w_dest      = 5'd31;
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    // $0 is hardwired; a write to it is dropped here so forwarding never sees it
    if (w_dest == 5'd0) w_reg_write = 1'b0;
  end

  assign w_imm = w_zext ? {16'h0000, w_imm16} : {{16{w_imm16[15]}}, w_imm16};

  assign w_hazard = r_ifid_valid & ex_valid & ex_mem_read & (ex_dest != 5'd0) &
                    ((w_use_rs & (ex_dest == w_rs)) | (w_use_rt & (ex_dest == w_rt))) & ~flush;
  assign stall_out = LOAD_USE_STALL ? w_hazard : 1'b0;
  assign w_bubble  = flush | stall_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_opcode      <= '0;
      ex_funct       <= '0;
      ex_shamt       <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_dest        <= '0;
      ex_imm         <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_illegal     <= 1'b0;
    end else begin
      ex_valid       <= r_ifid_valid;
      ex_pc          <= r_ifid_pc;
      ex_opcode      <= w_op;
      ex_funct       <= w_funct;
      ex_shamt       <= r_ifid_insn[10:6];
      ex_rs          <= w_rs;
      ex_rt          <= w_rt;
      ex_dest        <= w_dest;
      ex_imm         <= w_imm;
      ex_alu_src_imm <= w_alu_src_imm;
      ex_mem_read    <= w_mem_read & r_ifid_valid;
      ex_mem_write   <= w_mem_write & r_ifid_valid;
      ex_reg_write   <= w_reg_write & r_ifid_valid;
      ex_illegal     <= w_illegal & r_ifid_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a latency scoreboard,
// then hand sequences for load-use stalls, flush, and asynchronous reset mid-stall.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        flush;
  logic        stall_out;
  logic [4:0]  rf_source1;
  logic [4:0]  rf_source2;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic [31:0] ex_imm;
  logic        ex_alu_src_imm;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_illegal;

  decode_stage #(.PC_W(32), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_insn(if_insn), .if_pc(if_pc),
    .flush(flush), .stall_out(stall_out), .rf_source1(rf_source1), .rf_source2(rf_source2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_imm(ex_imm),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        src;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        ill;
  } vec_t;

  typedef logic [101:0] idex_t;

  localparam int NV = 15;
  vec_t  vt[NV];
  idex_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic idex_t idex();
    return {ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt, ex_rs, ex_rt, ex_dest, ex_imm,
            ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal};
  endfunction

  function automatic idex_t exp_of(input vec_t v, input logic [31:0] pc);
    return {1'b1, pc, v.insn[31:26], v.insn[5:0], v.insn[10:6], v.insn[25:21], v.insn[20:16],
            v.dest, v.imm, v.src, v.mr, v.mw, v.rw, v.ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    if_valid = v;
    if_insn  = insn;
    if_pc    = pc;
  endtask

  initial begin
    vt[0]  = '{32'h20050007, 5'd5,  32'h00000007, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{32'h34638000, 5'd3,  32'h00008000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{32'h2063FFFF, 5'd3,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{32'h01025020, 5'd10, 32'h00005020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{32'hAFA40008, 5'd0,  32'h00000008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{32'h1022FFFC, 5'd0,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h08000100, 5'd0,  32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h0C000040, 5'd31, 32'h00000040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{32'hFC000000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{32'h00220001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{32'h00010080, 5'd0,  32'h00000080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h8D280000, 5'd8,  32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[12] = '{32'h30C7FFFF, 5'd7,  32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{32'h3C091234, 5'd9,  32'h00001234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{32'h03E00008, 5'd0,  32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_idex", 128'(idex()), 128'(0));
    chk("reset_stall", 128'(stall_out), 128'(0));
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;

    // table through the two-edge latency scoreboard
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vt[i].insn, 32'h1000 + 32'(4 * i));
      sbq.push_back(exp_of(vt[i], 32'h1000 + 32'(4 * i)));
      tick();
      chk($sformatf("rf_src1[%0d]", i), 128'(rf_source1), 128'(vt[i].insn[25:21]));
      chk($sformatf("rf_src2[%0d]", i), 128'(rf_source2), 128'(vt[i].insn[20:16]));
      chk($sformatf("no_stall[%0d]", i), 128'(stall_out), 128'(0));
      if (sbq.size() == 2) chk($sformatf("idex[%0d]", i), 128'(idex()), 128'(sbq.pop_front()));
    end
    drive(1'b0, 32'h0, 32'h0);
    sbq.push_back('0);
    tick();
    chk("drain0", 128'(idex()), 128'(sbq.pop_front()));
    tick();
    chk("drain1", 128'(idex()), 128'(sbq.pop_front()));

    // load-use: lw $8 then add $10,$8,$2
    drive(1'b1, 32'h8D280000, 32'h2000); tick();
    drive(1'b1, 32'h01025020, 32'h2004); tick();
    chk("lu_stall_on", 128'(stall_out), 128'(1));
    drive(1'b1, 32'h20050007, 32'h2008); tick();
    chk("lu_stall_off", 128'(stall_out), 128'(0));
    chk("lu_bubble", 128'({ex_valid, ex_mem_read, ex_reg_write}), 128'(0));
    chk("lu_held_rs", 128'(rf_source1), 128'(8));
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("lu_add_enters", 128'({ex_valid, ex_rs, ex_dest, ex_pc}), {95'd0, 1'b1, 5'd8, 5'd10, 32'h2004});
    tick();
    chk("lu_next", 128'({ex_valid, ex_dest, ex_pc}), {90'd0, 1'b1, 5'd5, 32'h2008});
    tick();

    // lw $0 never stalls a consumer of $0
    drive(1'b1, 32'h8D200000, 32'h2100); tick();
    drive(1'b1, 32'h00025020, 32'h2104); tick();
    chk("lw0_no_stall", 128'(stall_out), 128'(0));
    drive(1'b0, 32'h0, 32'h0); tick(); tick();

    // back-to-back loads to $8: each consumer stalls once
    drive(1'b1, 32'h8D280000, 32'h2200); tick();
    drive(1'b1, 32'h8D080004, 32'h2204); tick();
    chk("b2b_stall1", 128'(stall_out), 128'(1));
    drive(1'b1, 32'h01025020, 32'h2208); tick();
    chk("b2b_gap", 128'(stall_out), 128'(0));
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("b2b_stall2", 128'({stall_out, ex_valid, ex_mem_read, ex_pc}), {94'd0, 1'b1, 1'b1, 1'b1, 32'h2204});
    tick();
    chk("b2b_bubble2", 128'({stall_out, ex_valid}), 128'(0));
    tick();
    chk("b2b_add", 128'({ex_valid, ex_pc}), {95'd0, 1'b1, 32'h2208});
    tick();

    // flush in the stall cycle overrides the stall and kills IF/ID
    drive(1'b1, 32'h8D280000, 32'h3000); tick();
    drive(1'b1, 32'h01025020, 32'h3004); tick();
    chk("fl_pre_stall", 128'(stall_out), 128'(1));
    flush = 1'b1;
    #1;
    chk("fl_stall_killed", 128'(stall_out), 128'(0));
    drive(1'b1, 32'h20050007, 32'h3008); tick();
    flush = 1'b0;
    chk("fl_ex_bubble", 128'(ex_valid), 128'(0));
    drive(1'b1, 32'h34638000, 32'h3010); tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_ifid_dead", 128'(ex_valid), 128'(0));
    tick();
    chk("fl_next_ok", 128'({ex_valid, ex_pc, ex_imm}), {63'd0, 1'b1, 32'h3010, 32'h00008000});
    tick();

    // asynchronous reset between edges while stalled
    drive(1'b1, 32'h8D280000, 32'h4000); tick();
    drive(1'b1, 32'h01025020, 32'h4004); tick();
    chk("rs_pre_stall", 128'(stall_out), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_idex", 128'(idex()), 128'(0));
    chk("rs_async_stall", 128'(stall_out), 128'(0));
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rs_after_release", 128'({stall_out, idex()}), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
